// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_pkg
// Purpose  : Shared defaults and constants for the register-file write
//            arbiter and its holding slots.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_write_arbiter_pkg;

  // Default datapath sizes
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 4;

  // Requester indices as seen by the arbiter
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  // last_grant comes out of reset pointing at the memory requester, so the
  // ALU requester wins the first tie.
  localparam logic LAST_GRANT_RST = REQ_MEM;

endpackage : regfile_write_arbiter_pkg
`default_nettype wire

// File: rtl/regfile_write_arbiter_wb_hold_slot.sv
`default_nettype none
// ============================================================================
// Module   : wb_hold_slot
// Purpose  : One-entry writeback holding register. Loads address/data on a
//            transfer and drops its valid bit when granted, unless a new
//            transfer reloads it on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
module wb_hold_slot
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  valid_d, valid_q;
  logic [ADDR_WIDTH-1:0] addr_d,  addr_q;
  logic [DATA_WIDTH-1:0] data_d,  data_q;

  // Next-state: a load always wins over a clear (refill on grant edge)
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (i_load) begin
      valid_d = 1'b1;
      addr_d  = i_addr;
      data_d  = i_data;
    end else if (i_clear) begin
      valid_d = 1'b0;
    end
  end

  // Slot storage; contents are discarded on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_addr  = addr_q;
  assign o_data  = data_q;

endmodule : wb_hold_slot
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the register-file write port between the ALU writeback
//            (req0) and the memory-load writeback (req1). Each requester has
//            a one-entry holding slot; a round-robin arbiter drains the slots
//            into a registered write port.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy
);

  logic                  hold0_v, hold1_v;
  logic [ADDR_WIDTH-1:0] hold0_addr, hold1_addr;
  logic [DATA_WIDTH-1:0] hold0_data, hold1_data;

  logic                  grant_valid;
  logic                  grant_idx;
  logic                  grant0, grant1;
  logic                  load0, load1;

  logic                  last_grant_d, last_grant_q;
  logic                  wr_en_d, wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_d, wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_d, wr_data_q;

  wb_hold_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hold0 (
    .clk     (clk),
    .reset   (reset),
    .i_load  (load0),
    .i_clear (grant0),
    .i_addr  (req0_addr),
    .i_data  (req0_data),
    .o_valid (hold0_v),
    .o_addr  (hold0_addr),
    .o_data  (hold0_data)
  );

  wb_hold_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hold1 (
    .clk     (clk),
    .reset   (reset),
    .i_load  (load1),
    .i_clear (grant1),
    .i_addr  (req1_addr),
    .i_data  (req1_data),
    .o_valid (hold1_v),
    .o_addr  (hold1_addr),
    .o_data  (hold1_data)
  );

  // Round-robin grant: a lone occupant wins, a tie goes to the other side
  always_comb begin
    grant_valid = hold0_v | hold1_v;
    grant_idx   = REQ_ALU;
    if (hold0_v && hold1_v) begin
      grant_idx = ~last_grant_q;
    end else if (hold1_v) begin
      grant_idx = REQ_MEM;
    end
  end

  assign grant0 = grant_valid && (grant_idx == REQ_ALU);
  assign grant1 = grant_valid && (grant_idx == REQ_MEM);

  // A slot being drained this cycle can accept a refill on the same edge
  assign req0_ready = !hold0_v || grant0;
  assign req1_ready = !hold1_v || grant1;
  assign load0      = req0_valid && req0_ready;
  assign load1      = req1_valid && req1_ready;

  // Output register next-state; address/data hold when nothing is granted
  always_comb begin
    wr_en_d      = grant_valid;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    last_grant_d = last_grant_q;
    if (grant_valid) begin
      wr_addr_d    = (grant_idx == REQ_MEM) ? hold1_addr : hold0_addr;
      wr_data_d    = (grant_idx == REQ_MEM) ? hold1_data : hold0_data;
      last_grant_d = grant_idx;
    end
  end

  // Registered write port and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      last_grant_q <= LAST_GRANT_RST;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = hold0_v | hold1_v;

endmodule : regfile_write_arbiter
`default_nettype wire
